// File: rtl/vending_pkg.sv
// Shared vending datapath definitions: coin values, hopper bit positions,
// display status codes and the payout FSM state encoding.
package vending_pkg;

   localparam int DENOM_HI_DEF  = 5;
   localparam int DENOM_MID_DEF = 2;
   localparam int DENOM_LO_DEF  = 1;

   localparam int HOP_HI  = 2;
   localparam int HOP_MID = 1;
   localparam int HOP_LO  = 0;

   localparam logic [1:0] STATUS_IDLE   = 2'b00;
   localparam logic [1:0] STATUS_PAYING = 2'b10;
   localparam logic [1:0] STATUS_ERROR  = 2'b11;
   localparam logic [1:0] STATUS_DONE   = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_REQ    = 3'd2,
      S_DONE   = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

endpackage

// File: rtl/denom_select.sv
// Greedy coin picker: largest stocked denomination that still fits in the
// remaining amount, as a one-hot hopper select plus its value.
module denom_select
   import vending_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DENOM_HI  = DENOM_HI_DEF,
   parameter int DENOM_MID = DENOM_MID_DEF,
   parameter int DENOM_LO  = DENOM_LO_DEF
) (
   input  logic [WIDTH-1:0] remaining,
   input  logic [2:0]       hopper_empty,
   output logic [2:0]       sel,
   output logic [WIDTH-1:0] d,
   output logic             found
);

   localparam logic [WIDTH-1:0] D_HI  = WIDTH'(DENOM_HI);
   localparam logic [WIDTH-1:0] D_MID = WIDTH'(DENOM_MID);
   localparam logic [WIDTH-1:0] D_LO  = WIDTH'(DENOM_LO);

   always_comb begin
      sel   = '0;
      d     = '0;
      found = 1'b0;
      if (!hopper_empty[HOP_HI] && remaining >= D_HI) begin
         sel[HOP_HI] = 1'b1;
         d           = D_HI;
         found       = 1'b1;
      end else if (!hopper_empty[HOP_MID] && remaining >= D_MID) begin
         sel[HOP_MID] = 1'b1;
         d            = D_MID;
         found        = 1'b1;
      end else if (!hopper_empty[HOP_LO] && remaining >= D_LO) begin
         sel[HOP_LO] = 1'b1;
         d           = D_LO;
         found       = 1'b1;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: pays an accepted amount one coin at a time over
// a req/ack hopper handshake, reporting jams or empty hoppers as shortfall.
// Handshakes: change is taken on a posedge with change_valid & ready; a coin
// request is held until the posedge where coin_ack is seen with it high.
module change_dispenser
   import vending_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int ACK_TIMEOUT = 15,
   parameter int DENOM_HI    = DENOM_HI_DEF,
   parameter int DENOM_MID   = DENOM_MID_DEF,
   parameter int DENOM_LO    = DENOM_LO_DEF
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [WIDTH-1:0] change,
   input  logic             change_valid,
   output logic             ready,
   input  logic [2:0]       hopper_empty,
   output logic [2:0]       coin_req,
   input  logic             coin_ack,
   input  logic             err_clr,
   output logic             done,
   output logic             error,
   output logic [WIDTH-1:0] shortfall,
   output logic [WIDTH-1:0] coins_paid,
   output logic [1:0]       status,
   output logic [2:0]       fsm_state
);

   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

   state_t           state;
   logic [WIDTH-1:0] remaining;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] pick_d;
   logic [2:0]       pick_sel;
   logic             pick_found;
   logic [TW-1:0]    timer;

   denom_select #(
      .WIDTH    (WIDTH),
      .DENOM_HI (DENOM_HI),
      .DENOM_MID(DENOM_MID),
      .DENOM_LO (DENOM_LO)
   ) u_denom_select (
      .remaining   (remaining),
      .hopper_empty(hopper_empty),
      .sel         (pick_sel),
      .d           (pick_d),
      .found       (pick_found)
   );

   // SELECT guarantees d <= remaining, so this never wraps.
   assign rem_next  = remaining - d_reg;
   assign fsm_state = state;

   always_ff @(posedge clock) begin
      if (clear) begin
         state      <= S_IDLE;
         ready      <= 1'b1;
         coin_req   <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
         shortfall  <= '0;
         coins_paid <= '0;
         status     <= STATUS_IDLE;
         remaining  <= '0;
         d_reg      <= '0;
         timer      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (change_valid) begin
                  remaining  <= change;
                  coins_paid <= '0;
                  shortfall  <= '0;
                  ready      <= 1'b0;
                  if (change == '0) begin
                     state  <= S_DONE;
                     done   <= 1'b1;
                     status <= STATUS_DONE;
                  end else begin
                     state  <= S_SELECT;
                     status <= STATUS_PAYING;
                  end
               end
            end
            S_SELECT: begin
               if (pick_found) begin
                  state    <= S_REQ;
                  coin_req <= pick_sel;
                  d_reg    <= pick_d;
                  timer    <= '0;
               end else begin
                  state     <= S_ERROR;
                  shortfall <= remaining;
                  error     <= 1'b1;
                  status    <= STATUS_ERROR;
               end
            end
            S_REQ: begin
               if (coin_ack) begin
                  coin_req  <= '0;
                  remaining <= rem_next;
                  if (coins_paid != '1) coins_paid <= coins_paid + 1'b1;
                  if (rem_next == '0) begin
                     state  <= S_DONE;
                     done   <= 1'b1;
                     status <= STATUS_DONE;
                  end else begin
                     state <= S_SELECT;
                  end
               end else if (timer == TIMER_LAST) begin
                  // Jam: the requested coin never dropped.
                  coin_req  <= '0;
                  shortfall <= remaining;
                  error     <= 1'b1;
                  status    <= STATUS_ERROR;
                  state     <= S_ERROR;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_DONE: begin
               done   <= 1'b0;
               status <= STATUS_IDLE;
               ready  <= 1'b1;
               state  <= S_IDLE;
            end
            S_ERROR: begin
               if (err_clr) begin
                  error  <= 1'b0;
                  status <= STATUS_IDLE;
                  ready  <= 1'b1;
                  state  <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table of payout vectors with a hopper model and
// a coin-request scoreboard, plus hand sequences for reset-in-REQ.
module tb_change_dispenser;
   import vending_pkg::*;

   logic       clock = 1'b0;
   logic       clear;
   logic [3:0] change;
   logic       change_valid;
   logic       ready;
   logic [2:0] hopper_empty;
   logic [2:0] coin_req;
   logic       coin_ack;
   logic       err_clr;
   logic       done;
   logic       error;
   logic [3:0] shortfall;
   logic [3:0] coins_paid;
   logic [1:0] status;
   logic [2:0] fsm_state;

   always #5 clock = ~clock;

   change_dispenser dut (
      .clock       (clock),
      .clear       (clear),
      .change      (change),
      .change_valid(change_valid),
      .ready       (ready),
      .hopper_empty(hopper_empty),
      .coin_req    (coin_req),
      .coin_ack    (coin_ack),
      .err_clr     (err_clr),
      .done        (done),
      .error       (error),
      .shortfall   (shortfall),
      .coins_paid  (coins_paid),
      .status      (status),
      .fsm_state   (fsm_state)
   );

   typedef struct {
      logic [3:0]  change;
      logic [2:0]  empty;
      int          dly;
      int          jam;
      int          n;
      logic [17:0] seq;
      logic        err;
      logic [3:0]  shortv;
      logic [3:0]  paid;
      logic        poke;
   } vec_t;

   vec_t       vecs[$];
   logic [2:0] exp_q[$];
   logic [2:0] seen_q[$];
   int         n_vec = 0;
   int         n_bad = 0;
   int         cur_dly = 0;
   int         cur_jam = -1;
   int         coin_idx = 0;
   int         wait_cnt = 0;
   logic [2:0] mon_prev = 3'b000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] c, input logic [2:0] e, input int dly,
                               input int jam, input int n, input logic [17:0] seq,
                               input logic err, input logic [3:0] sh, input logic [3:0] paid,
                               input logic poke);
      vec_t v;
      v.change = c; v.empty = e; v.dly = dly; v.jam = jam; v.n = n; v.seq = seq;
      v.err = err; v.shortv = sh; v.paid = paid; v.poke = poke;
      return v;
   endfunction

   // Hopper model: acks after cur_dly REQ cycles, never acks coin number cur_jam.
   initial begin
      coin_ack = 1'b0;
      forever begin
         @(negedge clock);
         if (coin_req == 3'b000) begin
            if (coin_ack) coin_idx++;
            coin_ack = 1'b0;
            wait_cnt = 0;
            if (ready) coin_idx = 0;
         end else if (!coin_ack && coin_idx != cur_jam) begin
            if (wait_cnt >= cur_dly) coin_ack = 1'b1;
            else wait_cnt++;
         end
      end
   end

   // Records each new coin request as it appears.
   initial begin
      forever begin
         @(negedge clock);
         if (coin_req != 3'b000 && mon_prev == 3'b000) seen_q.push_back(coin_req);
         mon_prev = coin_req;
      end
   end

   task automatic drain(input string tag);
      logic [2:0] got;
      while (seen_q.size() > 0) begin
         got = seen_q.pop_front();
         if (exp_q.size() == 0) check({tag, " unexpected coin_req"}, 32'(got), 32'd0);
         else check({tag, " coin_req order"}, 32'(got), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic accept(input logic [3:0] c);
      int cyc;
      cyc = 0;
      @(negedge clock);
      while (!ready && cyc < 50) begin
         @(negedge clock);
         cyc++;
      end
      check("ready before accept", 32'(ready), 32'd1);
      change       = c;
      change_valid = 1'b1;
      @(posedge clock);
      #1;
      change_valid = 1'b0;
      change       = 4'($urandom_range(0, 15));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int cyc;
      int done_cnt;
      logic got;
      hopper_empty = v.empty;
      cur_dly      = v.dly;
      cur_jam      = v.jam;
      for (int i = 0; i < v.n; i++) exp_q.push_back(v.seq[3*(v.n-1-i) +: 3]);
      accept(v.change);
      cyc = 0; done_cnt = 0; got = 1'b0;
      while (!got && cyc < 100) begin
         @(negedge clock);
         cyc++;
         drain(tag);
         if (v.poke && cyc == 3) begin
            change_valid = 1'b1;
            change       = 4'hf;
            err_clr      = 1'b1;
         end
         if (v.poke && cyc == 5) begin
            change_valid = 1'b0;
            err_clr      = 1'b0;
         end
         if (done) begin
            done_cnt++;
            got = 1'b1;
         end else if (error) begin
            got = 1'b1;
         end
      end
      change_valid = 1'b0;
      err_clr      = 1'b0;
      check({tag, " outcome before timeout"}, 32'(got), 32'd1);
      check({tag, " error"}, 32'(error), 32'(v.err));
      check({tag, " coins_paid"}, 32'(coins_paid), 32'(v.paid));
      if (!v.err && v.dly == 0 && v.jam < 0 && !v.poke)
         check({tag, " latency"}, 32'(cyc), 32'(2*v.n + 1));
      if (v.err) begin
         check({tag, " shortfall"}, 32'(shortfall), 32'(v.shortv));
         check({tag, " status err"}, 32'(status), 32'(STATUS_ERROR));
         check({tag, " coin_req idle"}, 32'(coin_req), 32'd0);
         check({tag, " ready in error"}, 32'(ready), 32'd0);
         @(negedge clock);
         drain(tag);
         check({tag, " error holds"}, 32'(error), 32'd1);
         err_clr = 1'b1;
         @(negedge clock);
         err_clr = 1'b0;
         check({tag, " ready after err_clr"}, 32'(ready), 32'd1);
         check({tag, " error cleared"}, 32'(error), 32'd0);
         check({tag, " shortfall held"}, 32'(shortfall), 32'(v.shortv));
      end else begin
         check({tag, " done count"}, 32'(done_cnt), 32'd1);
         check({tag, " status done"}, 32'(status), 32'(STATUS_DONE));
         @(negedge clock);
         drain(tag);
         check({tag, " done single pulse"}, 32'(done), 32'd0);
         check({tag, " status idle"}, 32'(status), 32'(STATUS_IDLE));
         check({tag, " ready after done"}, 32'(ready), 32'd1);
      end
      check({tag, " coins_paid after"}, 32'(coins_paid), 32'(v.paid));
      check({tag, " missing coin_req"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " ready"}, 32'(ready), 32'd1);
      check({tag, " coin_req"}, 32'(coin_req), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " error"}, 32'(error), 32'd0);
      check({tag, " shortfall"}, 32'(shortfall), 32'd0);
      check({tag, " coins_paid"}, 32'(coins_paid), 32'd0);
      check({tag, " status"}, 32'(status), 32'(STATUS_IDLE));
      check({tag, " state"}, 32'(fsm_state), 32'(S_IDLE));
   endtask

   initial begin
      int cyc;
      clear        = 1'b1;
      change       = 4'd0;
      change_valid = 1'b0;
      hopper_empty = 3'b000;
      err_clr      = 1'b0;
      repeat (2) @(posedge clock);
      #1 clear = 1'b0;
      @(negedge clock);
      check_reset_outputs("reset");

      vecs.push_back(mk(4'd8,  3'b000, 1, -1, 3, {3'b100, 3'b010, 3'b001}, 1'b0, 4'd0, 4'd3, 1'b0));
      vecs.push_back(mk(4'd6,  3'b100, 1, -1, 3, {3'b010, 3'b010, 3'b010}, 1'b0, 4'd0, 4'd3, 1'b0));
      vecs.push_back(mk(4'd3,  3'b011, 0, -1, 0, 18'd0, 1'b1, 4'd3, 4'd0, 1'b0));
      vecs.push_back(mk(4'd7,  3'b000, 1,  1, 2, {3'b100, 3'b010}, 1'b1, 4'd2, 4'd1, 1'b0));
      vecs.push_back(mk(4'd0,  3'b000, 0, -1, 0, 18'd0, 1'b0, 4'd0, 4'd0, 1'b0));
      vecs.push_back(mk(4'd8,  3'b000, 0, -1, 3, {3'b100, 3'b010, 3'b001}, 1'b0, 4'd0, 4'd3, 1'b0));
      vecs.push_back(mk(4'd15, 3'b000, 0, -1, 3, {3'b100, 3'b100, 3'b100}, 1'b0, 4'd0, 4'd3, 1'b0));
      vecs.push_back(mk(4'd4,  3'b010, 0, -1, 4, {3'b001, 3'b001, 3'b001, 3'b001}, 1'b0, 4'd0, 4'd4, 1'b0));
      vecs.push_back(mk(4'd9,  3'b100, $urandom_range(0, 3), -1, 5,
                        {3'b010, 3'b010, 3'b010, 3'b010, 3'b001}, 1'b0, 4'd0, 4'd5, 1'b0));
      vecs.push_back(mk(4'd7,  3'b001, 0, -1, 2, {3'b100, 3'b010}, 1'b0, 4'd0, 4'd2, 1'b0));
      vecs.push_back(mk(4'd8,  3'b001, 0, -1, 2, {3'b100, 3'b010}, 1'b1, 4'd1, 4'd2, 1'b0));
      vecs.push_back(mk(4'd1,  3'b111, 0, -1, 0, 18'd0, 1'b1, 4'd1, 4'd0, 1'b0));
      vecs.push_back(mk(4'd14, 3'b000, $urandom_range(0, 3), -1, 4,
                        {3'b100, 3'b100, 3'b010, 3'b010}, 1'b0, 4'd0, 4'd4, 1'b0));
      vecs.push_back(mk(4'd8,  3'b000, 2, -1, 3, {3'b100, 3'b010, 3'b001}, 1'b0, 4'd0, 4'd3, 1'b1));

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Clear while a $5 request is outstanding, then a fresh $1 payout.
      hopper_empty = 3'b000;
      cur_dly      = 0;
      cur_jam      = 0;
      exp_q.push_back(3'b100);
      accept(4'd8);
      cyc = 0;
      while (coin_req != 3'b100 && cyc < 20) begin
         @(negedge clock);
         cyc++;
      end
      check("clear_mid coin_req before clear", 32'(coin_req), 32'b100);
      clear = 1'b1;
      @(posedge clock);
      #1 clear = 1'b0;
      @(negedge clock);
      drain("clear_mid");
      check_reset_outputs("clear_mid");
      check("clear_mid missing coin_req", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      run_vec(mk(4'd1, 3'b000, 0, -1, 1, {3'b001}, 1'b0, 4'd0, 4'd1, 1'b0), "after_clear");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
